rst_seq: RTL and testbench

RST_SEQ -- requirements
Module: rst_seq

---
 rtl/rst_seq_pkg.sv | 19 +
 rtl/rst_seq_cnt.sv | 32 +++
 rtl/rst_seq.sv | 125 ++++++++++++
 tb/tb_rst_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state type and default parameters for the reset sequencer
package rst_seq_pkg;

    localparam int DEF_NUM_DOM     = 3;
    localparam int DEF_HOLD_CYC    = 16;
    localparam int DEF_ACK_TIMEOUT = 255;

    typedef enum logic [1:0] {
        SEQ_HOLD,
        SEQ_WAIT_ACK,
        SEQ_DONE,
        SEQ_ERR
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// rtl/rst_seq_cnt.sv - saturating loadable up-counter with clear and terminal compare
module rst_seq_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] term_val,
    output logic         at_term
);

    logic [W-1:0] cnt;

    // Saturates at all-ones so a long stall can never alias back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign at_term = (cnt == term_val);

endmodule

// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - releases downstream reset domains in order, one per ack, with hold and timeout
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOM     = DEF_NUM_DOM,
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sw_rst_req,
    input  logic [NUM_DOM-1:0]         dom_ack,
    output logic [NUM_DOM-1:0]         dom_rst_n,
    output logic                       seq_done,
    output logic                       seq_err,
    output logic [$clog2(NUM_DOM)-1:0] err_dom
);

    localparam int IW = $clog2(NUM_DOM);
    localparam int CW = $clog2(max_int(HOLD_CYC, ACK_TIMEOUT) + 1);
    localparam logic [IW-1:0] LAST = IW'(NUM_DOM - 1);

    seq_state_t    state;
    logic [IW-1:0] idx;
    logic [IW-1:0] first_drop;
    logic [CW-1:0] term_val;
    logic          cur_ack;
    logic          at_term;
    logic          cnt_clr;
    logic          cnt_inc;

    assign cur_ack  = dom_ack[idx];
    assign term_val = (state == SEQ_HOLD) ? CW'(HOLD_CYC - 1) : CW'(ACK_TIMEOUT);

    always_comb begin
        first_drop = '0;
        for (int i = NUM_DOM - 1; i >= 0; i--) begin
            if (!dom_ack[i]) first_drop = IW'(i);
        end
    end

    always_comb begin
        cnt_clr = 1'b1;
        cnt_inc = 1'b0;
        if (!sw_rst_req) begin
            case (state)
                SEQ_HOLD: begin
                    cnt_clr = at_term;
                    cnt_inc = !at_term;
                end
                SEQ_WAIT_ACK: begin
                    cnt_clr = cur_ack;
                    cnt_inc = !cur_ack && !at_term;
                end
                default: ;
            endcase
        end
    end

    rst_seq_cnt #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (cnt_inc),
        .term_val (term_val),
        .at_term  (at_term)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SEQ_HOLD;
            idx       <= '0;
            dom_rst_n <= '0;
            seq_done  <= 1'b0;
            seq_err   <= 1'b0;
            err_dom   <= '0;
        end else if (sw_rst_req) begin
            state     <= SEQ_HOLD;
            idx       <= '0;
            dom_rst_n <= '0;
            seq_done  <= 1'b0;
            seq_err   <= 1'b0;
            err_dom   <= '0;
        end else begin
            case (state)
                SEQ_HOLD: begin
                    if (at_term) begin
                        idx          <= '0;
                        dom_rst_n[0] <= 1'b1;
                        state        <= SEQ_WAIT_ACK;
                    end
                end
                SEQ_WAIT_ACK: begin
                    if (cur_ack) begin
                        if (idx == LAST) begin
                            seq_done <= 1'b1;
                            state    <= SEQ_DONE;
                        end else begin
                            dom_rst_n[idx + IW'(1)] <= 1'b1;
                            idx                     <= idx + IW'(1);
                        end
                    end else if (at_term) begin
                        seq_err   <= 1'b1;
                        err_dom   <= idx;
                        dom_rst_n <= '0;
                        state     <= SEQ_ERR;
                    end
                end
                SEQ_DONE: begin
                    if (!(&dom_ack)) begin
                        seq_done  <= 1'b0;
                        seq_err   <= 1'b1;
                        err_dom   <= first_drop;
                        dom_rst_n <= '0;
                        state     <= SEQ_ERR;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq.sv
// tb/tb_rst_seq.sv - vector table, async reset corners and random run against a sequencing model
module tb_rst_seq;

    localparam int N    = 3;
    localparam int HOLD = 16;
    localparam int TMO  = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic [2:0] dom_ack = 3'b000;
    logic [2:0] dom_rst_n;
    logic       seq_done;
    logic       seq_err;
    logic [1:0] err_dom;

    int tests = 0;
    int fails = 0;

    rst_seq #(.NUM_DOM(N), .HOLD_CYC(HOLD), .ACK_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_rst_req (sw_rst_req),
        .dom_ack    (dom_ack),
        .dom_rst_n  (dom_rst_n),
        .seq_done   (seq_done),
        .seq_err    (seq_err),
        .err_dom    (err_dom)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       sw;
        logic [2:0] ack;
        int         n;
        logic [2:0] rn;
        logic       done;
        logic       err;
        logic [1:0] edom;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string name, input logic sw, input logic [2:0] ack, input int n,
                       input logic [2:0] rn, input logic done, input logic err, input logic [1:0] edom);
        vec_t v;
        v.name = name; v.sw = sw; v.ack = ack; v.n = n;
        v.rn = rn; v.done = done; v.err = err; v.edom = edom;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [2:0] e_rn, input logic e_done,
                       input logic e_err, input logic [1:0] e_edom);
        tests++;
        if (dom_rst_n !== e_rn || seq_done !== e_done || seq_err !== e_err || err_dom !== e_edom) begin
            fails++;
            $display("FAIL %s: got rst_n=%b done=%b err=%b err_dom=%0d, want rst_n=%b done=%b err=%b err_dom=%0d",
                     name, dom_rst_n, seq_done, seq_err, err_dom, e_rn, e_done, e_err, e_edom);
        end
    endtask

    // Reference model: how many domains are released, how long we've waited, and the status flags.
    int m_rel, m_cnt, m_edom;
    bit m_done, m_err;

    task automatic model_reset();
        m_rel = 0; m_cnt = 0; m_edom = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_step(input bit sw, input logic [2:0] ack);
        if (sw) begin
            model_reset();
        end else if (m_err) begin
        end else if (m_done) begin
            if (ack != 3'b111) begin
                for (int i = N - 1; i >= 0; i--) if (!ack[i]) m_edom = i;
                m_err = 1; m_done = 0; m_rel = 0;
            end
        end else if (m_rel == 0) begin
            if (m_cnt == HOLD - 1) begin m_rel = 1; m_cnt = 0; end
            else m_cnt++;
        end else if (ack[m_rel-1]) begin
            if (m_rel == N) m_done = 1;
            else begin m_rel++; m_cnt = 0; end
        end else if (m_cnt == TMO) begin
            m_err = 1; m_edom = m_rel - 1; m_rel = 0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        add("hold15",     0, 3'b000,  15, 3'b000, 0, 0, 0);
        add("rise0",      0, 3'b000,   1, 3'b001, 0, 0, 0);
        add("wait0",      0, 3'b000,   2, 3'b001, 0, 0, 0);
        add("rise1",      0, 3'b001,   1, 3'b011, 0, 0, 0);
        add("wait1",      0, 3'b001,   2, 3'b011, 0, 0, 0);
        add("rise2",      0, 3'b011,   1, 3'b111, 0, 0, 0);
        add("wait2",      0, 3'b011,   2, 3'b111, 0, 0, 0);
        add("done",       0, 3'b111,   1, 3'b111, 1, 0, 0);
        add("done_hold",  0, 3'b111,   5, 3'b111, 1, 0, 0);
        add("ack_loss",   0, 3'b010,   1, 3'b000, 0, 1, 0);
        add("err_hold",   0, 3'b111,  10, 3'b000, 0, 1, 0);
        add("sw_clear",   1, 3'b111,   1, 3'b000, 0, 0, 0);
        add("hold_junk",  0, 3'b111,  15, 3'b000, 0, 0, 0);
        add("rise0b",     0, 3'b111,   1, 3'b001, 0, 0, 0);
        add("rise1b",     0, 3'b111,   1, 3'b011, 0, 0, 0);
        add("rise2b",     0, 3'b111,   1, 3'b111, 0, 0, 0);
        add("doneb",      0, 3'b111,   1, 3'b111, 1, 0, 0);
        add("sw2",        1, 3'b000,   1, 3'b000, 0, 0, 0);
        add("hold3",      0, 3'b001,  15, 3'b000, 0, 0, 0);
        add("rise0c",     0, 3'b001,   1, 3'b001, 0, 0, 0);
        add("rise1c",     0, 3'b101,   1, 3'b011, 0, 0, 0);
        add("tmo_pre",    0, 3'b101, 255, 3'b011, 0, 0, 0);
        add("tmo",        0, 3'b101,   1, 3'b000, 0, 1, 1);
        add("tmo_hold",   0, 3'b111,  20, 3'b000, 0, 1, 1);
        add("sw3",        1, 3'b111,   1, 3'b000, 0, 0, 0);
        add("hold4",      0, 3'b011,  16, 3'b001, 0, 0, 0);
        add("rise1d",     0, 3'b011,   1, 3'b011, 0, 0, 0);
        add("rise2d",     0, 3'b011,   1, 3'b111, 0, 0, 0);
        add("sw_vs_ack",  1, 3'b111,   1, 3'b000, 0, 0, 0);
        add("hold5",      0, 3'b111,  15, 3'b000, 0, 0, 0);
        add("rise0e",     0, 3'b111,   1, 3'b001, 0, 0, 0);

        #1 rst = 1'b1;
        #1 chk("reset_async", 3'b000, 0, 0, 0);
        tick(2);
        chk("reset_state", 3'b000, 0, 0, 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            sw_rst_req = tbl[i].sw;
            dom_ack    = tbl[i].ack;
            tick(tbl[i].n);
            chk(tbl[i].name, tbl[i].rn, tbl[i].done, tbl[i].err, tbl[i].edom);
        end
        sw_rst_req = 1'b0;

        // Async reset between edges while domain 1 is waiting.
        dom_ack = 3'b001;
        tick(1);
        chk("pre_rst_idx1", 3'b011, 0, 0, 0);
        #2 rst = 1'b1;
        #1 chk("async_rst_mid", 3'b000, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        dom_ack = 3'b111;
        tick(HOLD - 1);
        chk("rehold", 3'b000, 0, 0, 0);
        tick(1);
        chk("rerise0", 3'b001, 0, 0, 0);
        tick(3);
        chk("redone", 3'b111, 1, 0, 0);
        #2 rst = 1'b1;
        #1 chk("async_rst_done", 3'b000, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        model_reset();
        begin
            int stuck;
            logic [2:0] a;
            bit s;
            stuck = 1;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                for (int i = 0; i < N; i++) begin
                    if (i < m_rel) a[i] = (i == stuck) ? 1'b0 : ($urandom_range(0, 39) != 0);
                    else           a[i] = 1'($urandom_range(0, 1));
                end
                s = m_err ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 299) == 0);
                if (s) stuck = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
                dom_ack    = a;
                sw_rst_req = s;
                @(posedge clk);
                model_step(s, a);
                @(negedge clk);
                chk("rand", 3'((1 << m_rel) - 1), m_done, m_err, 2'(m_edom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
